// File: rtl/alu_pkg.sv
// Shared constants for the ALU loader path: button count and the index of each
// button channel. The debouncer and the loader both import this package.
package alu_pkg;

    localparam int unsigned NB_BUTTONS  = 3;

    // Button channel indices; the one-hot press pulse for channel i is (1 << i).
    localparam int unsigned BTN_LOAD_A  = 0;
    localparam int unsigned BTN_LOAD_B  = 1;
    localparam int unsigned BTN_LOAD_OP = 2;

    // One-hot press codes as seen by the loader.
    localparam logic [NB_BUTTONS-1:0] CODE_LOAD_A  = NB_BUTTONS'(1) << BTN_LOAD_A;
    localparam logic [NB_BUTTONS-1:0] CODE_LOAD_B  = NB_BUTTONS'(1) << BTN_LOAD_B;
    localparam logic [NB_BUTTONS-1:0] CODE_LOAD_OP = NB_BUTTONS'(1) << BTN_LOAD_OP;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchroniser, stability counter and debounced level.
// Ports:
//   i_clock   system clock, rising edge
//   i_reset   asynchronous active-low reset
//   i_raw     raw asynchronous button level (1 = pressed)
//   o_level   debounced level (registered)
//   o_rise_c  combinational; high in the cycle whose edge accepts a 0->1 change
module debounce_channel #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000    // legal range >= 1
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise_c
);

    localparam int unsigned NB_COUNTER = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [NB_COUNTER-1:0] LAST_COUNT = NB_COUNTER'(DEBOUNCE_CYCLES - 1);

    logic                  r_sync1;
    logic                  r_sync2;
    logic                  r_stable;
    logic [NB_COUNTER-1:0] r_count;

    logic w_differs;
    logic w_accept;

    assign w_differs = r_sync2 ^ r_stable;
    assign w_accept  = w_differs && (r_count == LAST_COUNT);

    // Synchroniser: only r_sync2 is used downstream.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Count consecutive disagreeing cycles; any agreement restarts the count.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_count  <= '0;
            r_stable <= 1'b0;
        end else if (!w_differs) begin
            r_count  <= '0;
        end else if (w_accept) begin
            r_stable <= r_sync2;
            r_count  <= '0;
        end else begin
            r_count  <= r_count + NB_COUNTER'(1);
        end
    end

    assign o_level  = r_stable;
    assign o_rise_c = w_accept & r_sync2;

endmodule

// File: rtl/button_debouncer.sv
// Debounces N_BUTTONS raw push-buttons and emits a registered one-hot, single-cycle
// press pulse per accepted press. Simultaneous presses are serialised lowest index
// first; none are lost.
// Ports:
//   i_clock    system clock, rising edge
//   i_reset    asynchronous active-low reset
//   i_buttons  raw button levels (1 = pressed), asynchronous to i_clock
//   o_pulses   registered press pulses, at most one bit set, one cycle each
//   o_levels   debounced button levels (registered)
module button_debouncer
    import alu_pkg::*;
#(
    parameter int unsigned N_BUTTONS       = NB_BUTTONS,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000    // legal range >= 1
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic [N_BUTTONS-1:0] i_buttons,
    output logic [N_BUTTONS-1:0] o_pulses,
    output logic [N_BUTTONS-1:0] o_levels
);

    logic [N_BUTTONS-1:0] w_rise;
    logic [N_BUTTONS-1:0] w_cand;
    logic [N_BUTTONS-1:0] w_grant;
    logic [N_BUTTONS-1:0] r_pending;
    logic [N_BUTTONS-1:0] r_pulses;

    // One debounce channel per button.
    for (genvar g = 0; g < int'(N_BUTTONS); g++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_chan (
            .i_clock  (i_clock),
            .i_reset  (i_reset),
            .i_raw    (i_buttons[g]),
            .o_level  (o_levels[g]),
            .o_rise_c (w_rise[g])
        );
    end

    // Lowest set bit of new rises plus still-pending presses wins this cycle.
    always_comb begin
        w_cand  = '0;
        w_grant = '0;
        w_cand  = w_rise | r_pending;
        w_grant = w_cand & (~w_cand + N_BUTTONS'(1));
    end

    // A re-rise on a channel already pending merges into the same pending bit.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_pulses  <= '0;
            r_pending <= '0;
        end else begin
            r_pulses  <= w_grant;
            r_pending <= w_cand & ~w_grant;
        end
    end

    assign o_pulses = r_pulses;

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer. A timestamp-based reference model pushes the
// expected outputs of every edge into a queue; a negedge monitor pops and compares.
// Directed scenario results are queued the same way and compared by the monitor.
module tb_button_debouncer;

    localparam int N   = 3;
    localparam int DC  = 4;
    localparam int LAT = DC + 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] buttons;
    logic [N-1:0] pulses;
    logic [N-1:0] levels;

    int checks = 0;
    int errors = 0;

    button_debouncer #(
        .N_BUTTONS       (N),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .i_clock   (clk),
        .i_reset   (rst_n),
        .i_buttons (buttons),
        .o_pulses  (pulses),
        .o_levels  (levels)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt++;

    // Reference model: a channel's sampled level (raw delayed by two edges) is accepted
    // once it has held a value different from the accepted level for DC edges.
    logic [2*N-1:0] sb_q[$];
    logic [N-1:0]   m_raw_q[$];
    logic [N-1:0]   m_stable;
    logic [N-1:0]   m_prev_s;
    logic [N-1:0]   m_pend;
    int             m_edge = 0;
    int             m_last_chg[N];

    always @(posedge clk or negedge rst_n) begin : model
        logic [N-1:0] s;
        logic [N-1:0] rise;
        logic [N-1:0] cand;
        logic [N-1:0] pulse;
        if (!rst_n) begin
            m_raw_q.delete();
            m_raw_q.push_back('0);
            m_raw_q.push_back('0);
            m_stable = '0;
            m_prev_s = '0;
            m_pend   = '0;
            for (int c = 0; c < N; c++) m_last_chg[c] = m_edge;
            sb_q.delete();
            sb_q.push_back('0);
        end else begin
            m_edge++;
            s = m_raw_q.pop_front();
            m_raw_q.push_back(buttons);
            rise = '0;
            for (int c = 0; c < N; c++) begin
                if (s[c] != m_prev_s[c]) m_last_chg[c] = m_edge;
                if (s[c] != m_stable[c] && (m_edge - m_last_chg[c] + 1) >= DC) begin
                    m_stable[c] = s[c];
                    rise[c]     = s[c];
                end
            end
            m_prev_s = s;
            cand  = rise | m_pend;
            pulse = '0;
            for (int c = 0; c < N; c++) begin
                if (cand[c] && pulse == '0) pulse[c] = 1'b1;
            end
            m_pend = cand & ~pulse;
            sb_q.push_back({pulse, m_stable});
        end
    end

    // Directed results queued by the stimulus process, compared by the monitor.
    string dir_name[$];
    int    dir_act[$];
    int    dir_req[$];

    int pulse_cnt[N];
    int last_edge[N];
    initial begin
        for (int c = 0; c < N; c++) begin
            pulse_cnt[c] = 0;
            last_edge[c] = -1000;
        end
    end

    // Monitor: one scoreboard entry per cycle, one-hot check, directed results.
    always @(negedge clk) begin : monitor
        logic [2*N-1:0] exp_v;
        string          nm;
        int             act;
        int             req;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_empty edge=%0d no expected entry available", edge_cnt);
        end else begin
            exp_v = sb_q.pop_front();
            if ({pulses, levels} !== exp_v) begin
                errors++;
                $display("FAIL outputs edge=%0d pulses=%b levels=%b required pulses=%b levels=%b",
                         edge_cnt, pulses, levels, exp_v[2*N-1:N], exp_v[N-1:0]);
            end
        end
        checks++;
        if ($countones(pulses) > 1) begin
            errors++;
            $display("FAIL onehot edge=%0d pulses=%b required at most one bit", edge_cnt, pulses);
        end
        for (int c = 0; c < N; c++) begin
            if (pulses[c] == 1'b1) begin
                pulse_cnt[c]++;
                last_edge[c] = edge_cnt;
            end
        end
        while (dir_name.size() > 0) begin
            nm  = dir_name.pop_front();
            act = dir_act.pop_front();
            req = dir_req.pop_front();
            checks++;
            if (act != req) begin
                errors++;
                $display("FAIL %s actual=%0d required=%0d", nm, act, req);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic expect_int(input string name, input int act, input int req);
        dir_name.push_back(name);
        dir_act.push_back(act);
        dir_req.push_back(req);
    endtask

    initial begin : stim
        int chg;
        int rel;
        int base0;
        int base1;
        int base2;
        int hold[N];

        // Reset with all buttons pressed: outputs must stay 0.
        rst_n   = 1'b0;
        buttons = '1;
        step(5);
        buttons = '0;
        rst_n   = 1'b1;
        step(3);

        // Clean press and release on channel 0.
        base0   = pulse_cnt[0];
        buttons = 3'b001;
        chg     = edge_cnt;
        step(20);
        expect_int("press_count", pulse_cnt[0] - base0, 1);
        expect_int("press_latency", last_edge[0] - chg, LAT);
        buttons = 3'b000;
        step(20);
        expect_int("release_no_pulse", pulse_cnt[0] - base0, 1);

        // Bounce on channel 1, then held.
        base1 = pulse_cnt[1];
        for (int i = 0; i < 6; i++) begin
            buttons[1] = (i % 2 == 0);
            step(2);
        end
        buttons[1] = 1'b1;
        chg        = edge_cnt;
        step(20);
        expect_int("bounce_count", pulse_cnt[1] - base1, 1);
        expect_int("bounce_latency", last_edge[1] - chg, LAT);
        buttons = 3'b000;
        step(20);

        // Short glitch on channel 2.
        base2      = pulse_cnt[2];
        buttons[2] = 1'b1;
        step(3);
        buttons[2] = 1'b0;
        step(15);
        expect_int("glitch_count", pulse_cnt[2] - base2, 0);

        // Simultaneous press on channels 0 and 2.
        base0   = pulse_cnt[0];
        base2   = pulse_cnt[2];
        buttons = 3'b101;
        chg     = edge_cnt;
        step(20);
        expect_int("simul_count0", pulse_cnt[0] - base0, 1);
        expect_int("simul_count2", pulse_cnt[2] - base2, 1);
        expect_int("simul_latency0", last_edge[0] - chg, LAT);
        expect_int("simul_latency2", last_edge[2] - chg, LAT + 1);
        buttons = 3'b000;
        step(20);

        // Reset in the middle of a count on channel 0.
        base0   = pulse_cnt[0];
        buttons = 3'b001;
        step(3);
        rst_n   = 1'b0;
        step(2);
        expect_int("reset_mid_no_pulse", pulse_cnt[0] - base0, 0);
        rst_n   = 1'b1;
        rel     = edge_cnt;
        step(20);
        expect_int("reset_mid_count", pulse_cnt[0] - base0, 1);
        expect_int("reset_mid_latency", last_edge[0] - rel, LAT);
        buttons = 3'b000;
        step(20);

        // Random hold times per channel with occasional one-cycle resets.
        for (int c = 0; c < N; c++) hold[c] = 0;
        repeat (3000) begin
            for (int c = 0; c < N; c++) begin
                if (hold[c] == 0) begin
                    buttons[c] = ~buttons[c];
                    hold[c]    = $urandom_range(1, 9);
                end else begin
                    hold[c]--;
                end
            end
            rst_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            step(1);
        end
        rst_n   = 1'b1;
        buttons = '0;
        step(20);
        @(negedge clk);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
